text_buffer: RTL and testbench
==============================

TEXT_BUFFER -- requirements
Module: text_buffer

Interface
REQ-001 The block SHALL have a parameter COLS, default 16, giving the characters per display row; 256 must be an exact multiple of COLS.
REQ-002 The block SHALL have a parameter BLANK, default 8'h20, giving the fill character written by reset, clear and backspace.
REQ-003 clk  input  1  single system clock; every register updates on its rising edge.
REQ-004 reset  input  1  synchronous, active-high reset.
REQ-005 we  input  1  direct-write strobe; writes wdata to addr.
REQ-006 addr  input  8  direct-write character index, 0..255.
REQ-007 wdata  input  8  direct-write ASCII code.
REQ-008 put  input  1  terminal-style append strobe; applies put_char at the cursor.
REQ-009 put_char  input  8  ASCII code or control code for append.
REQ-010 clear  input  1  request to blank the whole screen.
REQ-011 busy  output  1  high while the clear sweep runs.
REQ-012 cursor  output  8  current append position, 0..255.
REQ-013 char_data  output  8 x 256 array  registered character buffer that feeds the VGA character renderer; index 0 is the top-left cell, row-major.

Function
REQ-014 The FSM SHALL have two states: IDLE and CLEAR.
REQ-015 In IDLE, at most one request SHALL take effect per cycle, with priority clear > put > we; a lower-priority request in the same cycle is dropped, not queued.
REQ-016 In IDLE with clear=1, the FSM SHALL go to CLEAR and load sweep index 0; busy goes high on the next cycle.
REQ-017 In CLEAR, each cycle SHALL write BLANK to char_data[sweep] and increment sweep; after the write to index 255 the FSM returns to IDLE.
REQ-018 A clear sweep SHALL take exactly 256 cycles with busy=1; on the IDLE return, busy falls and cursor becomes 0.
REQ-019 In CLEAR, we, put and clear SHALL be ignored.
REQ-020 A direct write (we) SHALL set char_data[addr] to wdata one cycle after the strobe and SHALL NOT change the cursor.
REQ-021 A put with a printable put_char (8'h20..8'h7E) SHALL write put_char to char_data[cursor] and increment the cursor modulo 256 (255 wraps to 0).
REQ-022 A put with 8'h0A (newline) SHALL write nothing and set cursor to ((cursor/COLS)+1)*COLS modulo 256.
REQ-023 A put with 8'h0D (carriage return) SHALL write nothing and set cursor to (cursor/COLS)*COLS.
REQ-024 A put with 8'h08 (backspace) SHALL, if cursor>0, decrement the cursor and write BLANK at the new position; at cursor=0 it does nothing.
REQ-025 A put with any other code SHALL be ignored.
REQ-026 All cursor arithmetic SHALL be 8-bit unsigned with natural wrap; COLS division uses constant shifts or masks only.
REQ-027 char_data SHALL be driven directly from registers, with no combinational path from inputs.

Reset
REQ-028 On reset=1 at a clock edge, every char_data entry SHALL become BLANK, cursor 0, state IDLE, sweep 0 and busy 0, with no sweep cycles.
REQ-029 Reset SHALL override any in-progress clear sweep and any concurrent request.
REQ-030 The cycle after reset deasserts, the block SHALL accept requests.

Structure
REQ-031 A shared package text_pkg SHALL hold the state enum (IDLE, CLEAR), the control-code constants (LF 8'h0A, CR 8'h0D, BS 8'h08), the default BLANK value and the 256-entry buffer depth.
REQ-032 One sub-module, cursor_next, SHALL compute the next cursor value and write-enable from cursor, put_char and COLS; it is purely combinational.
REQ-033 text_buffer SHALL hold the FSM, sweep counter, buffer registers and request priority logic.

Verification
REQ-034 Reset, then put 'H' (8'h48) and put 'i' (8'h69) -> char_data[0]=8'h48, char_data[1]=8'h69, cursor=2.
REQ-035 cursor=5, put 8'h0A, then put 8'h0D -> cursor=16 after the first, still 16 after the second; no buffer change.
REQ-036 cursor=255, put 'A' -> char_data[255]=8'h41, cursor=0; then backspace at cursor 0 -> no change.
REQ-037 Fill the buffer, pulse clear, drive we=1 during the sweep -> busy high exactly 256 cycles, all entries 8'h20, cursor 0, the direct write is lost.
REQ-038 Same cycle: put 'X' at cursor 3 and we addr=3 wdata 'Y' -> char_data[3]='X', cursor=4; assert reset mid-sweep at sweep=100 -> next cycle busy=0 and all entries 8'h20.

Source files
------------

// File: rtl/text_pkg.sv
// Shared constants for the character text buffer: FSM states, control codes,
// default fill character and buffer depth.
package text_pkg;

    localparam logic [0:0] S_IDLE  = 1'b0;
    localparam logic [0:0] S_CLEAR = 1'b1;

    localparam logic [7:0] LF            = 8'h0A;
    localparam logic [7:0] CR            = 8'h0D;
    localparam logic [7:0] BS            = 8'h08;
    localparam logic [7:0] BLANK_DEFAULT = 8'h20;

    localparam int DEPTH = 256;

    function automatic logic is_printable(input logic [7:0] c);
        return (c >= 8'h20) && (c <= 8'h7E);
    endfunction

endpackage

// File: rtl/cursor_next.sv
// Combinational terminal-append decoder: next cursor position and the buffer
// write (address, blank-vs-char) implied by one put_char at the current cursor.
module cursor_next
    import text_pkg::*;
#(
    parameter int COLS = 16
) (
    input  logic [7:0] cursor_i,
    input  logic [7:0] put_char_i,
    output logic [7:0] cursor_o,
    output logic       wr_en_o,
    output logic [7:0] wr_addr_o,
    output logic       wr_blank_o
);

    // COLS divides 256, so it is a power of two and row math is a mask.
    localparam logic [8:0] COLS9    = 9'(COLS);
    localparam logic [7:0] ROW_MASK = ~8'(COLS - 1);

    logic [7:0] row_base;
    logic [8:0] next_row;

    assign row_base = cursor_i & ROW_MASK;
    assign next_row = {1'b0, row_base} + COLS9;

    always_comb begin
        cursor_o   = cursor_i;
        wr_en_o    = 1'b0;
        wr_addr_o  = cursor_i;
        wr_blank_o = 1'b0;
        if (is_printable(put_char_i)) begin
            wr_en_o  = 1'b1;
            cursor_o = cursor_i + 8'd1;
        end else if (put_char_i == LF) begin
            cursor_o = next_row[7:0];
        end else if (put_char_i == CR) begin
            cursor_o = row_base;
        end else if (put_char_i == BS && cursor_i != 8'd0) begin
            cursor_o   = cursor_i - 8'd1;
            wr_en_o    = 1'b1;
            wr_addr_o  = cursor_i - 8'd1;
            wr_blank_o = 1'b1;
        end
    end

endmodule

// File: rtl/text_buffer.sv
// 256-cell character buffer for a VGA text renderer with direct writes,
// terminal-style append at a cursor, and a one-cell-per-cycle clear sweep.
module text_buffer
    import text_pkg::*;
#(
    parameter int         COLS  = 16,
    parameter logic [7:0] BLANK = BLANK_DEFAULT
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       we,
    input  logic [7:0] addr,
    input  logic [7:0] wdata,
    input  logic       put,
    input  logic [7:0] put_char,
    input  logic       clear,
    output logic       busy,
    output logic [7:0] cursor,
    output logic [7:0] char_data [0:DEPTH-1],
    output logic [0:0] dbg_state
);

    logic [0:0] state_q, state_d;
    logic [7:0] sweep_q, sweep_d;
    logic [7:0] cursor_q, cursor_d;
    logic [7:0] char_q [0:DEPTH-1];

    logic       wr_en;
    logic [7:0] wr_addr;
    logic [7:0] wr_data;

    logic [7:0] cn_cursor;
    logic       cn_wr_en;
    logic [7:0] cn_wr_addr;
    logic       cn_wr_blank;

    cursor_next #(.COLS(COLS)) u_cursor_next (
        .cursor_i   (cursor_q),
        .put_char_i (put_char),
        .cursor_o   (cn_cursor),
        .wr_en_o    (cn_wr_en),
        .wr_addr_o  (cn_wr_addr),
        .wr_blank_o (cn_wr_blank)
    );

    // One request per cycle in IDLE: clear beats put beats we; losers are dropped.
    always_comb begin
        state_d  = state_q;
        sweep_d  = sweep_q;
        cursor_d = cursor_q;
        wr_en    = 1'b0;
        wr_addr  = addr;
        wr_data  = wdata;
        if (state_q == S_IDLE) begin
            if (clear) begin
                state_d = S_CLEAR;
                sweep_d = 8'd0;
            end else if (put) begin
                cursor_d = cn_cursor;
                wr_en    = cn_wr_en;
                wr_addr  = cn_wr_addr;
                wr_data  = cn_wr_blank ? BLANK : put_char;
            end else if (we) begin
                wr_en   = 1'b1;
                wr_addr = addr;
                wr_data = wdata;
            end
        end else begin
            wr_en   = 1'b1;
            wr_addr = sweep_q;
            wr_data = BLANK;
            sweep_d = sweep_q + 8'd1;
            if (sweep_q == 8'hFF) begin
                state_d  = S_IDLE;
                cursor_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= S_IDLE;
            sweep_q  <= 8'd0;
            cursor_q <= 8'd0;
            for (int i = 0; i < DEPTH; i++) begin
                char_q[i] <= BLANK;
            end
        end else begin
            state_q  <= state_d;
            sweep_q  <= sweep_d;
            cursor_q <= cursor_d;
            if (wr_en) begin
                char_q[wr_addr] <= wr_data;
            end
        end
    end

    assign char_data = char_q;
    assign busy      = (state_q == S_CLEAR);
    assign cursor    = cursor_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_text_buffer.sv
// Randomized bench for text_buffer against a behavioural screen/cursor model
// plus directed scenarios for append, control codes, clear and reset.
module tb_text_buffer;
    import text_pkg::*;

    localparam int         COLS = 16;
    localparam logic [7:0] BL   = 8'h20;

    logic       clk = 1'b0;
    logic       reset, we, put, clear;
    logic [7:0] addr, wdata, put_char;
    logic       busy;
    logic [7:0] cursor;
    logic [7:0] char_data [0:255];
    logic [0:0] dbg_state;

    int checks   = 0;
    int failures = 0;

    // Model: screen contents, cursor, and clear cycles still to run.
    logic [7:0] m_mem [256];
    int         m_cursor;
    int         m_left;

    always #5 clk = ~clk;

    text_buffer #(.COLS(COLS), .BLANK(BL)) dut (
        .clk       (clk),
        .reset     (reset),
        .we        (we),
        .addr      (addr),
        .wdata     (wdata),
        .put       (put),
        .put_char  (put_char),
        .clear     (clear),
        .busy      (busy),
        .cursor    (cursor),
        .char_data (char_data),
        .dbg_state (dbg_state)
    );

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) m_mem[i] = BL;
        m_cursor = 0;
        m_left   = 0;
    endtask

    task automatic model_step(input bit w, input int a, input int wd,
                              input bit p, input int pc, input bit c);
        if (m_left > 0) begin
            m_left--;
            if (m_left == 0) m_cursor = 0;
        end else if (c) begin
            m_left = 256;
            for (int i = 0; i < 256; i++) m_mem[i] = BL;
        end else if (p) begin
            if (pc >= 32 && pc <= 126) begin
                m_mem[m_cursor] = 8'(pc);
                m_cursor = (m_cursor + 1) % 256;
            end else if (pc == 10) begin
                m_cursor = (((m_cursor / COLS) + 1) * COLS) % 256;
            end else if (pc == 13) begin
                m_cursor = (m_cursor / COLS) * COLS;
            end else if (pc == 8 && m_cursor > 0) begin
                m_cursor = m_cursor - 1;
                m_mem[m_cursor] = BL;
            end
        end else if (w) begin
            m_mem[a] = 8'(wd);
        end
    endtask

    task automatic cycle(input bit r, input bit w, input int a, input int wd,
                         input bit p, input int pc, input bit c);
        reset    = r;
        we       = w;
        addr     = 8'(a);
        wdata    = 8'(wd);
        put      = p;
        put_char = 8'(pc);
        clear    = c;
        @(posedge clk);
        #1;
        if (r) model_reset();
        else   model_step(w, a, wd, p, pc, c);
        check("busy", {31'd0, busy}, (m_left > 0) ? 32'd1 : 32'd0);
        check("state", {31'd0, dbg_state}, (m_left > 0) ? 32'd1 : 32'd0);
        check("cursor", {24'd0, cursor}, 32'(m_cursor));
    endtask

    task automatic idle();
        cycle(0, 0, 0, 0, 0, 0, 0);
    endtask

    task automatic do_put(input int pc);
        cycle(0, 0, 0, 0, 1, pc, 0);
    endtask

    task automatic check_buf(input string tag);
        for (int i = 0; i < 256; i++)
            check($sformatf("%s[%0d]", tag, i), {24'd0, char_data[i]}, {24'd0, m_mem[i]});
    endtask

    function automatic int rand_code();
        int k;
        k = $urandom_range(0, 9);
        if (k <= 5) return $urandom_range(32, 126);
        if (k == 6) return 10;
        if (k == 7) return 13;
        if (k == 8) return 8;
        if ($urandom_range(0, 1) == 1) return $urandom_range(127, 255);
        return $urandom_range(0, 7);
    endfunction

    initial begin
        int cnt;
        int n;

        // Reset overrides concurrent requests.
        cycle(1, 1, 5, 8'h55, 1, 8'h51, 1);
        cycle(1, 1, 5, 8'h55, 1, 8'h51, 1);
        check_buf("rst");

        do_put(8'h48);
        do_put(8'h69);
        check("hi_c0", {24'd0, char_data[0]}, 32'h48);
        check("hi_c1", {24'd0, char_data[1]}, 32'h69);
        check("hi_cursor", {24'd0, cursor}, 32'd2);

        do_put(8'h61);
        do_put(8'h62);
        do_put(8'h63);
        check("pre_lf_cursor", {24'd0, cursor}, 32'd5);
        do_put(8'h0A);
        check("lf_cursor", {24'd0, cursor}, 32'd16);
        do_put(8'h0D);
        check("cr_cursor", {24'd0, cursor}, 32'd16);
        check_buf("lfcr");

        for (int i = 0; i < 14; i++) do_put(8'h0A);
        for (int i = 0; i < 15; i++) do_put(8'h2E);
        check("pre_wrap_cursor", {24'd0, cursor}, 32'd255);
        do_put(8'h41);
        check("wrap_c255", {24'd0, char_data[255]}, 32'h41);
        check("wrap_cursor", {24'd0, cursor}, 32'd0);
        do_put(8'h08);
        check("bs0_cursor", {24'd0, cursor}, 32'd0);
        check_buf("bs0");

        for (int it = 0; it < 600; it++) begin
            cycle(0, $urandom_range(0, 1) == 1, $urandom_range(0, 255), $urandom_range(0, 255),
                  $urandom_range(0, 1) == 1, rand_code(), $urandom_range(0, 99) == 0);
            if (it % 32 == 31 && m_left == 0) check_buf("rand");
        end
        n = 0;
        while (busy && n < 300) begin
            idle();
            n++;
        end
        check_buf("rand_end");

        // Fill, clear, hammer requests during the sweep.
        for (int i = 0; i < 256; i++) cycle(0, 1, i, $urandom_range(33, 126), 0, 0, 0);
        check_buf("fill");
        cycle(0, 0, 0, 0, 0, 0, 1);
        cnt = busy ? 1 : 0;
        n = 0;
        while (busy && n < 400) begin
            cycle(0, 1, $urandom_range(0, 255), $urandom_range(33, 126),
                  $urandom_range(0, 1) == 1, rand_code(), $urandom_range(0, 1) == 1);
            if (busy) cnt++;
            n++;
        end
        check("clr_busy_cycles", 32'(cnt), 32'd256);
        check("clr_cursor", {24'd0, cursor}, 32'd0);
        check_buf("clr");

        // Put wins over a same-cycle direct write.
        cycle(1, 0, 0, 0, 0, 0, 0);
        do_put(8'h31);
        do_put(8'h32);
        do_put(8'h33);
        cycle(0, 1, 3, 8'h59, 1, 8'h58, 0);
        check("prio_c3", {24'd0, char_data[3]}, 32'h58);
        check("prio_cursor", {24'd0, cursor}, 32'd4);

        cycle(0, 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < 100; i++) idle();
        check("mid_busy", {31'd0, busy}, 32'd1);
        cycle(1, 0, 0, 0, 0, 0, 0);
        check("rst_mid_busy", {31'd0, busy}, 32'd0);
        check_buf("rst_mid");
        do_put(8'h5A);
        check("post_rst_c0", {24'd0, char_data[0]}, 32'h5A);
        check("post_rst_cursor", {24'd0, cursor}, 32'd1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
